result_uart_dumper: RTL and testbench
=====================================

RESULT_UART_DUMPER -- requirements
Module: result_uart_dumper

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, MAIN_CLOCK cycles per UART bit (50 MHz / 115200 baud); legal range 2 to 65535.
REQ-002 SHALL have parameter RESULT_BASE, default 16'h0000, RAM word address of the first result word.
REQ-003 SHALL have parameter RESULT_WORDS, default 9, number of 16-bit result words to dump; legal range 0 to 65535.
REQ-004 MAIN_CLOCK  input  1  sole clock; every flop updates on its rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 PROCESS_FINISHED  input  1  level from the processor; high once the program has halted.
REQ-007 RAM_DATA  input  16  read data from the data RAM.
REQ-008 RAM_ADDRESS  output  16  read address to the data RAM.
REQ-009 RAM_READ_EN  output  1  one-cycle read strobe.
REQ-010 BUSY  output  1  high while a dump is in progress; top level uses it to select this block as the RAM address owner.
REQ-011 DONE  output  1  sticky: all words sent.
REQ-012 UART_TX  output  1  serial line, 8N1, idle high.

Function
REQ-013 SHALL detect a rising edge of PROCESS_FINISHED, registered once in MAIN_CLOCK, as the dump trigger.
REQ-014 SHALL implement FSM states IDLE, READ, WAIT, SEND_HI, SEND_LO, NEXT, FINISHED.
REQ-015 IDLE->READ on trigger, or IDLE->FINISHED on trigger when RESULT_WORDS==0; word index is cleared to 0 on this transition.
REQ-016 READ: RAM_ADDRESS = RESULT_BASE + index, modulo 2^16 (wraps 16'hFFFF -> 16'h0000); RAM_READ_EN=1 for exactly this one cycle.
REQ-017 WAIT: RAM has one-cycle read latency; RAM_DATA SHALL be captured into a 16-bit holding register in this cycle; then go to SEND_HI.
REQ-018 SEND_HI: transmit holding[15:8]; SEND_LO: transmit holding[7:0]; each state is left only when the transmitter reports byte complete.
REQ-019 Byte frame SHALL be start bit 0, then data bits LSB first, then stop bit 1; each bit is held exactly CLKS_PER_BIT cycles, so one frame is 10*CLKS_PER_BIT cycles.
REQ-020 Byte frames SHALL be back-to-back with zero idle bit-times between them, including across word boundaries.
REQ-021 NEXT: increment index; go to FINISHED if index == RESULT_WORDS-1 before the increment, else go to READ.
REQ-022 FINISHED: DONE=1, BUSY=0, UART_TX=1; re-arm to IDLE (DONE cleared) only when PROCESS_FINISHED is low.
REQ-023 BUSY SHALL be 1 in all states except IDLE and FINISHED.
REQ-024 Triggers SHALL be ignored while BUSY=1, and SHALL NOT restart or extend the dump.
REQ-025 RAM_ADDRESS SHALL hold its last value outside READ; RAM_READ_EN SHALL be 0 outside READ.
REQ-026 UART_TX SHALL be driven from a flop (glitch-free).

Reset
REQ-027 While RESET=1: FSM=IDLE, index=0, holding=0, baud and bit counters=0, edge-detect flop=0, UART_TX=1, BUSY=0, DONE=0, RAM_READ_EN=0, RAM_ADDRESS=RESULT_BASE.
REQ-028 RESET asserted mid-frame SHALL drive UART_TX high on the next edge and abandon the dump; no partial resume.
REQ-029 If PROCESS_FINISHED is already high when RESET releases, no dump SHALL start until PROCESS_FINISHED falls and rises again.

Structure
REQ-030 FSM state encoding and the frame-length constant (10 bits) SHALL live in shared package dump_pkg.
REQ-031 Serialiser SHALL be one sub-module, uart_tx.
REQ-032 uart_tx ports: MAIN_CLOCK, RESET, 8-bit data, start, busy, byte_done (one-cycle pulse at the end of the stop bit), TX; parameter CLKS_PER_BIT.
REQ-033 uart_tx SHALL accept start in the same cycle as byte_done, to meet REQ-020.

Verification (CLKS_PER_BIT=4)
REQ-034 RESULT_WORDS=3, RESULT_BASE=16'h0010, RAM[10..12]=1234,ABCD,0001 -> decoded bytes 12,34,AB,CD,00,01; DONE rises 240 cycles after the first start bit.
REQ-035 Bit timing: every bit SHALL measure exactly 4 cycles, the start bit is 0, the stop bit is 1, and there is no gap between frames.
REQ-036 Pulse PROCESS_FINISHED low then high during byte 2 -> byte stream unchanged, exactly 6 bytes sent.
REQ-037 RESET asserted in the 3rd bit of byte 1 -> UART_TX=1, BUSY=0, and DONE=0 the cycle after the reset edge; no further RAM_READ_EN pulses.
REQ-038 RESULT_WORDS=0 -> trigger gives DONE=1 within 2 cycles, zero RAM_READ_EN pulses, and UART_TX constant 1.
REQ-039 RESULT_BASE=16'hFFFF, RESULT_WORDS=2 -> RAM_READ_EN pulses at addresses FFFF then 0000.

Source files
------------

// File: rtl/dump_pkg.sv
// Shared definitions for the result dumper: FSM state encoding and UART frame length.
package dump_pkg;

    // Dump sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        SEND_HI,
        SEND_LO,
        NEXT,
        FINISHED
    } state_t;

    // Start bit + 8 data bits + stop bit.
    localparam int unsigned FRAME_BITS = 10;

endpackage

// File: rtl/result_uart_dumper_if.sv
// Data-RAM read port used by the result dumper: address/strobe out, read data back.
interface result_uart_dumper_if;
    logic [15:0] RAM_ADDRESS;
    logic        RAM_READ_EN;
    logic [15:0] RAM_DATA;

    // Dumper side drives the address and read strobe.
    modport master (
        output RAM_ADDRESS,
        output RAM_READ_EN,
        input  RAM_DATA
    );

    // RAM side returns data one cycle after the strobe.
    modport slave (
        input  RAM_ADDRESS,
        input  RAM_READ_EN,
        output RAM_DATA
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART serialiser. A new byte may be started in the same cycle the previous
// frame reports byte_done, so frames can run back-to-back with no idle time.
module uart_tx
    import dump_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       MAIN_CLOCK,
    input  logic       RESET,
    input  logic [7:0] data,
    input  logic       start,
    output logic       busy,
    output logic       byte_done,
    output logic       TX
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  BIT_LAST  = 4'(FRAME_BITS - 1);

    logic [15:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic [8:0]  shifter;   // remaining data bits, then the stop bit
    logic        accept;

    // Last cycle of the stop bit; the next frame may be launched now.
    assign byte_done = busy && (baud_cnt == BAUD_LAST) && (bit_cnt == BIT_LAST);
    assign accept    = start && (!busy || byte_done);

    // Bit timing and serial shift; TX comes straight from a flop.
    always_ff @(posedge MAIN_CLOCK) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (RESET) begin
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shifter  <= '0;
            TX       <= 1'b1;
        end else if (accept) begin
            busy     <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shifter  <= {1'b1, data};
            TX       <= 1'b0;
        end else if (busy) begin
            if (baud_cnt == BAUD_LAST) begin
                baud_cnt <= '0;
                if (bit_cnt == BIT_LAST) begin
                    busy    <= 1'b0;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    TX      <= shifter[0];
                    shifter <= {1'b0, shifter[8:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/result_uart_dumper.sv
// Dumps RESULT_WORDS 16-bit words from the data RAM over a UART, high byte first,
// once the processor signals that the program has finished.
module result_uart_dumper
    import dump_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [15:0] RESULT_BASE  = 16'h0000,
    parameter int unsigned RESULT_WORDS = 9
) (
    input  logic                 MAIN_CLOCK,
    input  logic                 RESET,
    input  logic                 PROCESS_FINISHED,
    result_uart_dumper_if.master ram,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 UART_TX
);

    localparam logic [15:0] LAST_INDEX = 16'(RESULT_WORDS - 1);

    state_t      state;
    logic [15:0] index;
    logic [15:0] holding;
    logic        finished_q;   // PROCESS_FINISHED delayed one cycle
    logic        armed;        // PROCESS_FINISHED seen low since reset
    logic        trigger;
    logic        tx_start;
    logic        tx_busy;
    logic        tx_byte_done;
    logic        tx_ready;
    logic [7:0]  tx_data;

    // A level already high at reset release is not an edge: require a low first.
    assign trigger  = PROCESS_FINISHED && !finished_q && armed;
    // Transmitter can take a byte now (idle, or finishing the current frame).
    assign tx_ready = !tx_busy || tx_byte_done;
    assign tx_start = tx_ready && ((state == SEND_HI) || (state == SEND_LO));

    // Byte selection for the serialiser.
    always_comb begin
        // NOTE: default first so no path leaves tx_data unassigned (no latch).
        tx_data = holding[7:0];
        if (state == SEND_HI) tx_data = holding[15:8];
    end

    // Dump sequencer with registered RAM strobe, address, BUSY and DONE.
    always_ff @(posedge MAIN_CLOCK) begin
        if (RESET) begin
            state           <= IDLE;
            index           <= '0;
            holding         <= '0;
            finished_q      <= 1'b0;
            armed           <= 1'b0;
            BUSY            <= 1'b0;
            DONE            <= 1'b0;
            ram.RAM_READ_EN <= 1'b0;
            ram.RAM_ADDRESS <= RESULT_BASE;
        end else begin
            finished_q      <= PROCESS_FINISHED;
            armed           <= armed || !PROCESS_FINISHED;
            ram.RAM_READ_EN <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        index <= '0;
                        if (RESULT_WORDS == 0) begin
                            state <= FINISHED;
                            DONE  <= 1'b1;
                        end else begin
                            state           <= READ;
                            BUSY            <= 1'b1;
                            ram.RAM_ADDRESS <= RESULT_BASE;
                            ram.RAM_READ_EN <= 1'b1;
                        end
                    end
                end
                READ: state <= WAIT;
                WAIT: begin
                    holding <= ram.RAM_DATA;
                    state   <= SEND_HI;
                end
                SEND_HI: if (tx_ready) state <= SEND_LO;
                SEND_LO: if (tx_ready) state <= NEXT;
                NEXT: begin
                    // The next word is fetched while the low byte is still on
                    // the line, so its high byte can follow with no gap.
                    if (index == LAST_INDEX) begin
                        if (tx_byte_done) begin
                            index <= index + 16'd1;
                            state <= FINISHED;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end
                    end else begin
                        index           <= index + 16'd1;
                        state           <= READ;
                        ram.RAM_ADDRESS <= RESULT_BASE + index + 16'd1;
                        ram.RAM_READ_EN <= 1'b1;
                    end
                end
                FINISHED: begin
                    if (!PROCESS_FINISHED) begin
                        state <= IDLE;
                        DONE  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .MAIN_CLOCK(MAIN_CLOCK),
        .RESET     (RESET),
        .data      (tx_data),
        .start     (tx_start),
        .busy      (tx_busy),
        .byte_done (tx_byte_done),
        .TX        (UART_TX)
    );

endmodule

// File: tb/tb_result_uart_dumper.sv
// Directed bench for result_uart_dumper: three instances cover the main dump,
// an empty dump and an address that wraps through 16'hFFFF.
module tb_result_uart_dumper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, pf_a, busy_a, done_a, tx_a;
    logic rst_b, pf_z, busy_z, done_z, tx_z, pf_w, busy_w, done_w, tx_w;

    result_uart_dumper_if bus_a ();
    result_uart_dumper_if bus_z ();
    result_uart_dumper_if bus_w ();

    result_uart_dumper #(.CLKS_PER_BIT(4), .RESULT_BASE(16'h0010), .RESULT_WORDS(3)) dut_a (
        .MAIN_CLOCK(clk), .RESET(rst_a), .PROCESS_FINISHED(pf_a), .ram(bus_a),
        .BUSY(busy_a), .DONE(done_a), .UART_TX(tx_a));

    result_uart_dumper #(.CLKS_PER_BIT(4), .RESULT_BASE(16'h0010), .RESULT_WORDS(0)) dut_z (
        .MAIN_CLOCK(clk), .RESET(rst_b), .PROCESS_FINISHED(pf_z), .ram(bus_z),
        .BUSY(busy_z), .DONE(done_z), .UART_TX(tx_z));

    result_uart_dumper #(.CLKS_PER_BIT(4), .RESULT_BASE(16'hFFFF), .RESULT_WORDS(2)) dut_w (
        .MAIN_CLOCK(clk), .RESET(rst_b), .PROCESS_FINISHED(pf_w), .ram(bus_w),
        .BUSY(busy_w), .DONE(done_w), .UART_TX(tx_w));

    // RAM contents used by the directed cases.
    function automatic logic [15:0] ram_word(input logic [15:0] a);
        case (a)
            16'h0010: return 16'h1234;
            16'h0011: return 16'hABCD;
            16'h0012: return 16'h0001;
            16'hFFFF: return 16'hBEEF;
            16'h0000: return 16'hCAFE;
            default:  return 16'hDEAD;
        endcase
    endfunction

    // One-cycle read latency RAM models.
    always @(posedge clk) begin
        if (bus_a.RAM_READ_EN) bus_a.RAM_DATA <= ram_word(bus_a.RAM_ADDRESS);
        if (bus_z.RAM_READ_EN) bus_z.RAM_DATA <= ram_word(bus_z.RAM_ADDRESS);
        if (bus_w.RAM_READ_EN) bus_w.RAM_DATA <= ram_word(bus_w.RAM_ADDRESS);
    end

    // Monitors, sampled on the falling edge.
    logic        tx_trace [$];
    logic [15:0] addr_a   [$];
    logic [15:0] addr_w   [$];
    int   reads_a = 0, reads_z = 0, reads_w = 0;
    int   zeros_z = 0, busy_cnt_z = 0;
    int   done_rise_idx = -1;
    logic done_a_q = 1'b0;

    always @(negedge clk) begin
        tx_trace.push_back(tx_a);
        done_a_q <= done_a;
        if (done_a === 1'b1 && done_a_q !== 1'b1) done_rise_idx <= tx_trace.size() - 1;
        if (bus_a.RAM_READ_EN === 1'b1) begin
            reads_a <= reads_a + 1;
            addr_a.push_back(bus_a.RAM_ADDRESS);
        end
        if (bus_z.RAM_READ_EN === 1'b1) reads_z <= reads_z + 1;
        if (tx_z === 1'b0) zeros_z <= zeros_z + 1;
        if (busy_z === 1'b1) busy_cnt_z <= busy_cnt_z + 1;
        if (bus_w.RAM_READ_EN === 1'b1) begin
            reads_w <= reads_w + 1;
            addr_w.push_back(bus_w.RAM_ADDRESS);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] exp_bytes [6] = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};

    initial begin
        int snap, s0, bad, zeros, rsnap;
        logic [7:0] got_byte;
        logic mid;

        rst_a = 1'b1; rst_b = 1'b1;
        pf_a  = 1'b1;             // already high across reset release
        pf_z  = 1'b0; pf_w = 1'b0;
        tick(3);

        check("reset tx",       32'(tx_a), 32'd1);
        check("reset busy",     32'(busy_a), 32'd0);
        check("reset done",     32'(done_a), 32'd0);
        check("reset read_en",  32'(bus_a.RAM_READ_EN), 32'd0);
        check("reset address",  32'(bus_a.RAM_ADDRESS), 32'h0010);

        rst_a = 1'b0; rst_b = 1'b0;
        tick(30);
        check("high at release busy",  32'(busy_a), 32'd0);
        check("high at release reads", 32'(reads_a), 32'd0);

        // Main dump: fall then rise of PROCESS_FINISHED.
        pf_a = 1'b0;
        tick(3);
        snap  = tx_trace.size();
        rsnap = reads_a;
        pf_a  = 1'b1;
        for (int k = 0; k < 200 && tx_a !== 1'b0; k++) @(negedge clk);
        check("first start bit", 32'(tx_a), 32'd0);

        // Retrigger pulse inside byte 2 must be ignored.
        tick(50);
        pf_a = 1'b0;
        tick(2);
        pf_a = 1'b1;
        for (int k = 0; k < 600 && done_a !== 1'b1; k++) @(negedge clk);
        check("dump done", 32'(done_a), 32'd1);
        tick(60);

        s0 = snap;
        for (int i = snap; i < tx_trace.size(); i++) begin
            if (tx_trace[i] === 1'b0) begin
                s0 = i;
                break;
            end
        end

        for (int f = 0; f < 6; f++) begin
            bad = 0;
            got_byte = '0;
            for (int b = 0; b < 10; b++) begin
                if (b == 0)      mid = 1'b0;
                else if (b == 9) mid = 1'b1;
                else begin
                    mid = tx_trace[s0 + f*40 + b*4 + 1];
                    got_byte[b-1] = mid;
                end
                for (int c = 0; c < 4; c++)
                    if (tx_trace[s0 + f*40 + b*4 + c] !== mid) bad++;
            end
            check($sformatf("byte %0d value", f), 32'(got_byte), 32'(exp_bytes[f]));
            check($sformatf("byte %0d timing", f), 32'(bad), 32'd0);
        end

        check("done latency", 32'(done_rise_idx - s0), 32'd240);
        zeros = 0;
        for (int i = s0 + 240; i < tx_trace.size(); i++)
            if (tx_trace[i] !== 1'b1) zeros++;
        check("no extra frames", 32'(zeros), 32'd0);
        check("read pulses", 32'(reads_a - rsnap), 32'd3);
        check("read addr 0", 32'(addr_a[rsnap]),     32'h0010);
        check("read addr 1", 32'(addr_a[rsnap + 1]), 32'h0011);
        check("read addr 2", 32'(addr_a[rsnap + 2]), 32'h0012);
        check("finished busy",    32'(busy_a), 32'd0);
        check("address held",     32'(bus_a.RAM_ADDRESS), 32'h0012);
        check("read_en idle",     32'(bus_a.RAM_READ_EN), 32'd0);

        // Re-arm clears DONE.
        pf_a = 1'b0;
        tick(2);
        check("rearm done", 32'(done_a), 32'd0);

        // Reset during the third bit of the first byte.
        pf_a = 1'b1;
        for (int k = 0; k < 200 && tx_a !== 1'b0; k++) @(negedge clk);
        check("second dump start", 32'(tx_a), 32'd0);
        tick(9);
        rst_a = 1'b1;
        tick(1);
        check("midframe reset tx",   32'(tx_a), 32'd1);
        check("midframe reset busy", 32'(busy_a), 32'd0);
        check("midframe reset done", 32'(done_a), 32'd0);
        rst_a = 1'b0;
        rsnap = reads_a;
        snap  = tx_trace.size();
        tick(200);
        check("no reads after reset", 32'(reads_a - rsnap), 32'd0);
        zeros = 0;
        for (int i = snap; i < tx_trace.size(); i++)
            if (tx_trace[i] !== 1'b1) zeros++;
        check("line idle after reset", 32'(zeros), 32'd0);

        // Empty dump.
        pf_z = 1'b1;
        for (int k = 0; k < 2 && done_z !== 1'b1; k++) @(negedge clk);
        check("empty done", 32'(done_z), 32'd1);
        tick(20);
        check("empty reads",   32'(reads_z), 32'd0);
        check("empty tx low",  32'(zeros_z), 32'd0);
        check("empty busy",    32'(busy_cnt_z), 32'd0);

        // Address wrap through 16'hFFFF.
        pf_w = 1'b1;
        for (int k = 0; k < 400 && done_w !== 1'b1; k++) @(negedge clk);
        check("wrap done",   32'(done_w), 32'd1);
        check("wrap reads",  32'(reads_w), 32'd2);
        check("wrap addr 0", 32'(addr_w[0]), 32'hFFFF);
        check("wrap addr 1", 32'(addr_w[1]), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
